// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: HI/LO op encodings, default
// latencies and the controller state type. The decoder imports this as well.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 5;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> multiply/divide unit connection: issue side from the E/D
// stages, status and HI/LO back from the unit.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, md_use,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_use,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit result for MULT/MULTU/DIV/DIVU. res_vld drops on a
// zero divisor so the controller leaves HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_vld
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] divisor;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               signed_div;
  logic               neg_q;
  logic               neg_r;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic n);
    return n ? (~x + 32'd1) : x;
  endfunction

  always_comb begin
    sa64       = {{32{a[31]}}, a};
    sb64       = {{32{b[31]}}, b};
    sprod      = sa64 * sb64;
    uprod      = {32'd0, a} * {32'd0, b};
    signed_div = (op == OP_DIV);
    mag_a      = signed_div ? abs32(a) : a;
    mag_b      = signed_div ? abs32(b) : b;
    divisor    = (b == 32'd0) ? 32'd1 : mag_b;
    uq         = mag_a / divisor;
    ur         = mag_a % divisor;
    neg_q      = signed_div & (a[31] ^ b[31]);
    neg_r      = signed_div & a[31];

    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_vld = 1'b0;
    case (op)
      OP_MULT: begin
        res_hi  = sprod[63:32];
        res_lo  = sprod[31:0];
        res_vld = 1'b1;
      end
      OP_MULTU: begin
        res_hi  = uprod[63:32];
        res_lo  = uprod[31:0];
        res_vld = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_lo  = neg_if(uq, neg_q);
        res_hi  = neg_if(ur, neg_r);
        res_vld = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: accepts one HI/LO op when idle, models the
// multi-cycle latency with a down-counter and owns the HI/LO registers.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   md
);

  md_state_e              state, state_nxt;
  logic [MDU_CNT_W-1:0]   cnt, cnt_nxt;
  logic                   busy;
  logic                   load;
  logic                   wr_res;
  logic                   wr_hi_mt;
  logic                   wr_lo_mt;
  logic [31:0]            hi_q;
  logic [31:0]            lo_q;
  logic [2:0]             op_p0;
  logic [31:0]            a_p0;
  logic [31:0]            b_p0;
  logic [31:0]            res_hi;
  logic [31:0]            res_lo;
  logic                   res_vld;

  assign busy = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    wr_res    = 1'b0;
    wr_hi_mt  = 1'b0;
    wr_lo_mt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md.start) begin
          if (md_is_multi(md.op)) begin
            state_nxt = ST_RUN;
            load      = 1'b1;
            cnt_nxt   = ((md.op == OP_MULT) || (md.op == OP_MULTU))
                        ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
          end else begin
            wr_hi_mt = (md.op == OP_MTHI);
            wr_lo_mt = (md.op == OP_MTLO);
          end
        end
      end
      ST_RUN: begin
        if (cnt == MDU_CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          wr_res    = res_vld;
        end else begin
          cnt_nxt = cnt - MDU_CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (wr_res) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (wr_hi_mt) hi_q <= md.rs_val;
      if (wr_lo_mt) lo_q <= md.rs_val;
    end
  end

  // Stage p0: operands captured at issue, held for the whole busy window.
  always_ff @(posedge clk) begin
    if (load) begin
      op_p0 <= md.op;
      a_p0  <= md.rs_val;
      b_p0  <= md.rt_val;
    end
  end

  mdu_arith u_arith (
    .op      (op_p0),
    .a       (a_p0),
    .b       (b_p0),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .res_vld (res_vld)
  );

  assign md.busy      = busy;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.stall_req = reset & md.md_use & (busy | (md.start & md_is_multi(md.op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized bench for mdu_ctrl against an arithmetic
// reference model of HI/LO and a fixed-latency busy window.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO, using 64-bit host arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sb, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
      OP_DIV:   if (b != 32'd0) begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
      OP_DIVU:  if (b != 32'd0) begin l = a / b; h = a % b; end
      OP_MTHI:  h = a;
      OP_MTLO:  l = a;
      default: ;
    endcase
  endfunction

  // Issue one op and follow it to completion. inj_at >= 0 raises a second
  // start (inj_op) during that busy cycle; it must have no effect.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic mu, input int inj_at, input logic [2:0] inj_op);
    logic [31:0] nh, nl;
    int n;
    bit multi;
    multi = (o <= 3'd3);
    n = (o <= 3'd1) ? NM : ND;
    nh = exp_hi;
    nl = exp_lo;
    ref_op(o, a, b, nh, nl);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.md_use = mu;
    @(negedge clk);
    chk("issue_stall", {31'd0, bus.stall_req}, {31'd0, mu & multi});
    chk("issue_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (multi) begin
      for (int i = 0; i < n; i++) begin
        if (i == inj_at) begin
          bus.start = 1'b1; bus.op = inj_op;
          bus.rs_val = $urandom; bus.rt_val = $urandom;
        end
        @(negedge clk);
        chk("run_busy", {31'd0, bus.busy}, 32'd1);
        chk("run_hi_hold", bus.hi, exp_hi);
        chk("run_lo_hold", bus.lo, exp_lo);
        chk("run_stall", {31'd0, bus.stall_req}, {31'd0, mu});
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    exp_hi = nh;
    exp_lo = nl;
    @(negedge clk);
    chk("done_busy", {31'd0, bus.busy}, 32'd0);
    chk("done_hi", bus.hi, exp_hi);
    chk("done_lo", bus.lo, exp_lo);
    bus.md_use = 1'b0;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    checks = 0;
    failures = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    reset = 1'b0;
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs_val = 32'd9; bus.rt_val = 32'd3; bus.md_use = 1'b1;

    // Reset holds everything cleared and suppresses stall_req.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.start = 1'b0; bus.md_use = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, OP_MULT);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, OP_MULT);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, -1, OP_MULT);
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, OP_MULT);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'h0000_0000);

    do_op(OP_MTHI, 32'h11, 32'd0, 1'b1, -1, OP_MULT);
    do_op(OP_MTLO, 32'h22, 32'd0, 1'b0, -1, OP_MULT);
    do_op(OP_DIVU, 32'd5, 32'd0, 1'b1, -1, OP_MULT);
    chk("divz_hi", bus.hi, 32'h11);
    chk("divz_lo", bus.lo, 32'h22);

    // Starts raised while busy, including in the final busy cycle.
    do_op(OP_MULTU, 32'd1000, 32'd77, 1'b1, 2, OP_MTHI);
    chk("inj_hi", bus.hi, 32'd0);
    chk("inj_lo", bus.lo, 32'd77000);
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b1, ND - 1, OP_MULT);
    chk("inj_last_lo", bus.lo, 32'd14);
    chk("inj_last_hi", bus.hi, 32'd2);

    for (int k = 0; k < 12; k++) begin
      ro = 3'($urandom_range(0, 5));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
           (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom);
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NM - 1)) : -1,
            3'($urandom_range(0, 5)));
    end

    // Reset during the third busy cycle of a DIV aborts it.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.md_use = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("abort_stall_rst", {31'd0, bus.stall_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.md_use = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    for (int i = 0; i < ND + 2; i++) begin
      @(negedge clk);
      chk("abort_idle", {31'd0, bus.busy}, 32'd0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
    end
    do_op(OP_MTLO, 32'h1234, 32'd0, 1'b1, -1, OP_MULT);
    chk("mtlo_after_abort", bus.lo, 32'h1234);
    chk("mtlo_hi_after_abort", bus.hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
